// File: rtl/cu_id.sv
// cu_id: RV32I instruction decode stage.
// Decodes Cu_IR into control codes, immediates and register indices,
// registers everything on a decode edge and pulses IDU_ready for one cycle.
// A decode request seen during a stall is held pending until the stall clears.
// The rd of the last register-writing decode is tracked to flag
// back-to-back dependencies on rs1/rs2 through pipeline_override.
module cu_id (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        decode_start,
    input  logic        IDU_stall,
    input  logic [31:0] Cu_IR,
    output logic        IDU_ready,
    output logic [5:0]  Instruction_to_CU,
    output logic [4:0]  Instruction_to_ALU,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  shamt,
    output logic [31:0] pc_increment,
    output logic [1:0]  pipeline_override,
    output logic        invalid_instruction
);

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SYS
    } fmt_t;

    localparam logic [4:0] ALU_NONE = 5'd31;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = Cu_IR[6:0];
    assign f3     = Cu_IR[14:12];
    assign f7     = Cu_IR[31:25];
    assign imm_i  = {{20{Cu_IR[31]}}, Cu_IR[31:20]};
    assign imm_s  = {{20{Cu_IR[31]}}, Cu_IR[31:25], Cu_IR[11:7]};
    assign imm_b  = {{20{Cu_IR[31]}}, Cu_IR[7], Cu_IR[30:25], Cu_IR[11:8], 1'b0};
    assign imm_u  = {Cu_IR[31:12], 12'b0};
    assign imm_j  = {{12{Cu_IR[31]}}, Cu_IR[19:12], Cu_IR[20], Cu_IR[30:21], 1'b0};

    fmt_t        d_fmt;
    logic        d_valid;
    logic        d_wr;
    logic [5:0]  d_cu;
    logic [4:0]  d_alu;
    logic [31:0] d_imm;
    logic [4:0]  d_rd, d_rs1, d_rs2, d_shamt;
    logic [31:0] d_pc;
    logic [1:0]  d_ov;

    logic        pending_q;
    logic [4:0]  last_rd_q;
    logic        fire;

    assign fire = ~IDU_stall & (decode_start | pending_q);

    // Classify the word (code, ALU op, format), then fill the format's fields.
    always_comb begin
        d_fmt   = FMT_NONE;
        d_valid = 1'b0;
        d_wr    = 1'b0;
        d_cu    = 6'd0;
        d_alu   = ALU_NONE;
        d_imm   = 32'd0;
        d_rd    = 5'd0;
        d_rs1   = 5'd0;
        d_rs2   = 5'd0;
        d_shamt = 5'd0;
        d_pc    = 32'd0;
        case (opcode)
            7'b0110111: begin d_fmt = FMT_U; d_cu = 6'd1; d_alu = 5'd16; end
            7'b0010111: begin d_fmt = FMT_U; d_cu = 6'd2; d_alu = 5'd0;  end
            7'b1101111: begin d_fmt = FMT_J; d_cu = 6'd3; d_alu = 5'd0;  end
            7'b1100111: if (f3 == 3'b000) begin d_fmt = FMT_I; d_cu = 6'd4; d_alu = 5'd0; end
            7'b1100011: begin
                d_fmt = FMT_B;
                case (f3)
                    3'b000: begin d_cu = 6'd5;  d_alu = 5'd10; end
                    3'b001: begin d_cu = 6'd6;  d_alu = 5'd11; end
                    3'b100: begin d_cu = 6'd7;  d_alu = 5'd12; end
                    3'b101: begin d_cu = 6'd8;  d_alu = 5'd13; end
                    3'b110: begin d_cu = 6'd9;  d_alu = 5'd14; end
                    3'b111: begin d_cu = 6'd10; d_alu = 5'd15; end
                    default: d_fmt = FMT_NONE;
                endcase
            end
            7'b0000011: begin
                d_fmt = FMT_I;
                d_alu = 5'd0;
                case (f3)
                    3'b000: d_cu = 6'd11;
                    3'b001: d_cu = 6'd12;
                    3'b010: d_cu = 6'd13;
                    3'b100: d_cu = 6'd14;
                    3'b101: d_cu = 6'd15;
                    default: d_fmt = FMT_NONE;
                endcase
            end
            7'b0100011: begin
                d_fmt = FMT_S;
                d_alu = 5'd0;
                case (f3)
                    3'b000: d_cu = 6'd16;
                    3'b001: d_cu = 6'd17;
                    3'b010: d_cu = 6'd18;
                    default: d_fmt = FMT_NONE;
                endcase
            end
            7'b0010011: begin
                d_fmt = FMT_I;
                case (f3)
                    3'b000: begin d_cu = 6'd19; d_alu = 5'd0; end
                    3'b010: begin d_cu = 6'd20; d_alu = 5'd3; end
                    3'b011: begin d_cu = 6'd21; d_alu = 5'd4; end
                    3'b100: begin d_cu = 6'd22; d_alu = 5'd5; end
                    3'b110: begin d_cu = 6'd23; d_alu = 5'd8; end
                    3'b111: begin d_cu = 6'd24; d_alu = 5'd9; end
                    3'b001: if (f7 == 7'b0000000) begin d_cu = 6'd25; d_alu = 5'd2; end
                            else d_fmt = FMT_NONE;
                    3'b101: if (f7 == 7'b0000000) begin d_cu = 6'd26; d_alu = 5'd6; end
                            else if (f7 == 7'b0100000) begin d_cu = 6'd27; d_alu = 5'd7; end
                            else d_fmt = FMT_NONE;
                    default: d_fmt = FMT_NONE;
                endcase
            end
            7'b0110011: begin
                d_fmt = FMT_R;
                case ({f7, f3})
                    10'b0000000_000: begin d_cu = 6'd28; d_alu = 5'd0; end
                    10'b0100000_000: begin d_cu = 6'd29; d_alu = 5'd1; end
                    10'b0000000_001: begin d_cu = 6'd30; d_alu = 5'd2; end
                    10'b0000000_010: begin d_cu = 6'd31; d_alu = 5'd3; end
                    10'b0000000_011: begin d_cu = 6'd32; d_alu = 5'd4; end
                    10'b0000000_100: begin d_cu = 6'd33; d_alu = 5'd5; end
                    10'b0000000_101: begin d_cu = 6'd34; d_alu = 5'd6; end
                    10'b0100000_101: begin d_cu = 6'd35; d_alu = 5'd7; end
                    10'b0000000_110: begin d_cu = 6'd36; d_alu = 5'd8; end
                    10'b0000000_111: begin d_cu = 6'd37; d_alu = 5'd9; end
                    default: d_fmt = FMT_NONE;
                endcase
            end
            7'b0001111: if (f3 == 3'b000) begin d_fmt = FMT_SYS; d_cu = 6'd38; end
            7'b1110011: begin
                if (Cu_IR == 32'h0000_0073) begin d_fmt = FMT_SYS; d_cu = 6'd39; end
                else if (Cu_IR == 32'h0010_0073) begin d_fmt = FMT_SYS; d_cu = 6'd40; end
            end
            default: d_fmt = FMT_NONE;
        endcase

        // Unused fields stay zero; an unknown word clears the code and ALU op too.
        case (d_fmt)
            FMT_R: begin
                d_valid = 1'b1; d_wr = 1'b1; d_pc = 32'd4;
                d_rd = Cu_IR[11:7]; d_rs1 = Cu_IR[19:15]; d_rs2 = Cu_IR[24:20];
            end
            FMT_I: begin
                d_valid = 1'b1; d_wr = 1'b1; d_imm = imm_i;
                d_rd = Cu_IR[11:7]; d_rs1 = Cu_IR[19:15];
                d_pc = (d_cu == 6'd4) ? 32'd0 : 32'd4;
                if (d_cu >= 6'd25 && d_cu <= 6'd27) d_shamt = Cu_IR[24:20];
            end
            FMT_S: begin
                d_valid = 1'b1; d_imm = imm_s; d_pc = 32'd4;
                d_rs1 = Cu_IR[19:15]; d_rs2 = Cu_IR[24:20];
            end
            FMT_B: begin
                d_valid = 1'b1; d_imm = imm_b; d_pc = imm_b;
                d_rs1 = Cu_IR[19:15]; d_rs2 = Cu_IR[24:20];
            end
            FMT_U: begin
                d_valid = 1'b1; d_wr = 1'b1; d_imm = imm_u; d_pc = 32'd4;
                d_rd = Cu_IR[11:7];
            end
            FMT_J: begin
                d_valid = 1'b1; d_wr = 1'b1; d_imm = imm_j; d_pc = imm_j;
                d_rd = Cu_IR[11:7];
            end
            FMT_SYS: begin
                d_valid = 1'b1; d_alu = ALU_NONE; d_pc = 32'd4;
            end
            default: begin
                d_cu  = 6'd0;
                d_alu = ALU_NONE;
            end
        endcase
    end

    // Unused source fields are already zero, so x0 and unused sources never match.
    always_comb begin
        d_ov    = 2'b00;
        d_ov[0] = (d_rs1 != 5'd0) && (d_rs1 == last_rd_q);
        d_ov[1] = (d_rs2 != 5'd0) && (d_rs2 == last_rd_q);
    end

    // Register decoded outputs on a decode edge; track pending request and last rd.
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            IDU_ready           <= 1'b0;
            Instruction_to_CU   <= 6'd0;
            Instruction_to_ALU  <= 5'd0;
            imm                 <= 32'd0;
            rd                  <= 5'd0;
            rs1                 <= 5'd0;
            rs2                 <= 5'd0;
            shamt               <= 5'd0;
            pc_increment        <= 32'd0;
            pipeline_override   <= 2'b00;
            invalid_instruction <= 1'b0;
            pending_q           <= 1'b0;
            last_rd_q           <= 5'd0;
        end else begin
            IDU_ready <= fire;
            if (fire) begin
                Instruction_to_CU   <= d_cu;
                Instruction_to_ALU  <= d_alu;
                imm                 <= d_imm;
                rd                  <= d_rd;
                rs1                 <= d_rs1;
                rs2                 <= d_rs2;
                shamt               <= d_shamt;
                pc_increment        <= d_pc;
                pipeline_override   <= d_ov;
                invalid_instruction <= ~d_valid;
                pending_q           <= 1'b0;
                last_rd_q           <= d_wr ? d_rd : 5'd0;
            end else if (decode_start) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cu_id.sv
// tb_cu_id: scoreboard bench for cu_id with directed, hand-decoded vectors.
module tb_cu_id;

    logic        soc_clk = 1'b0;
    logic        reset = 1'b0;
    logic        decode_start = 1'b0;
    logic        IDU_stall = 1'b0;
    logic [31:0] Cu_IR = 32'd0;
    logic        IDU_ready;
    logic [5:0]  Instruction_to_CU;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [31:0] pc_increment;
    logic [1:0]  pipeline_override;
    logic        invalid_instruction;

    cu_id dut (
        .soc_clk(soc_clk),
        .reset(reset),
        .decode_start(decode_start),
        .IDU_stall(IDU_stall),
        .Cu_IR(Cu_IR),
        .IDU_ready(IDU_ready),
        .Instruction_to_CU(Instruction_to_CU),
        .Instruction_to_ALU(Instruction_to_ALU),
        .imm(imm),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .shamt(shamt),
        .pc_increment(pc_increment),
        .pipeline_override(pipeline_override),
        .invalid_instruction(invalid_instruction)
    );

    always #5 soc_clk = ~soc_clk;

    typedef struct packed {
        logic [5:0]  cu;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  shamt;
        logic [31:0] pc;
        logic [1:0]  ov;
        logic        inv;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    exp_t mon_e;
    exp_t act_now;
    int   checks = 0;
    int   errors = 0;

    assign act_now = {Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2,
                      shamt, pc_increment, pipeline_override, invalid_instruction};

    function automatic exp_t mk(input int cu, input int alu, input logic [31:0] im,
                                input int r_d, input int r_s1, input int r_s2,
                                input int sh, input logic [31:0] pc, input int ov,
                                input int inv);
        exp_t e;
        e.cu = 6'(cu); e.alu = 5'(alu); e.imm = im;
        e.rd = 5'(r_d); e.rs1 = 5'(r_s1); e.rs2 = 5'(r_s2); e.shamt = 5'(sh);
        e.pc = pc; e.ov = 2'(ov); e.inv = 1'(inv);
        return e;
    endfunction

    task automatic chk(input string name, input logic [97:0] act, input logic [97:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on each ready pulse; otherwise outputs must hold.
    always @(negedge soc_clk) begin
        if (!reset) begin
            last_exp = '0;
        end else if (IDU_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 98'(IDU_ready), 98'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("cu",        98'(Instruction_to_CU),   98'(mon_e.cu));
                chk("alu",       98'(Instruction_to_ALU),  98'(mon_e.alu));
                chk("imm",       98'(imm),                 98'(mon_e.imm));
                chk("rd",        98'(rd),                  98'(mon_e.rd));
                chk("rs1",       98'(rs1),                 98'(mon_e.rs1));
                chk("rs2",       98'(rs2),                 98'(mon_e.rs2));
                chk("shamt",     98'(shamt),               98'(mon_e.shamt));
                chk("pc_inc",    98'(pc_increment),        98'(mon_e.pc));
                chk("override",  98'(pipeline_override),   98'(mon_e.ov));
                chk("invalid",   98'(invalid_instruction), 98'(mon_e.inv));
                last_exp = mon_e;
            end
        end else begin
            chk("hold", 98'(act_now), 98'(last_exp));
        end
    end

    task automatic issue(input logic [31:0] ir, input exp_t e);
        @(negedge soc_clk);
        Cu_IR = ir;
        decode_start = 1'b1;
        exp_q.push_back(e);
        @(negedge soc_clk);
        decode_start = 1'b0;
    endtask

    task automatic stalled_issue(input logic [31:0] ir, input exp_t e, input int n);
        @(negedge soc_clk);
        Cu_IR = ir;
        decode_start = 1'b1;
        IDU_stall = 1'b1;
        @(negedge soc_clk);
        decode_start = 1'b0;
        repeat (n - 1) @(negedge soc_clk);
        IDU_stall = 1'b0;
        exp_q.push_back(e);
        @(negedge soc_clk);
    endtask

    initial begin
        repeat (2) @(negedge soc_clk);
        chk("reset_ready",   98'(IDU_ready), 98'(0));
        chk("reset_outputs", 98'(act_now),   98'(0));
        reset = 1'b1;
        repeat (3) begin
            @(negedge soc_clk);
            chk("idle_ready", 98'(IDU_ready), 98'(0));
        end

        issue(32'h0050_0093, mk(19, 0, 32'd5, 1, 0, 0, 0, 32'd4, 0, 0));
        issue(32'h0020_8133, mk(28, 0, 32'd0, 2, 1, 2, 0, 32'd4, 1, 0));
        issue(32'hFE00_0EE3, mk(5, 10, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0));
        stalled_issue(32'h4040_D193, mk(27, 7, 32'h0000_0404, 3, 1, 0, 4, 32'd4, 0, 0), 3);
        issue(32'hFFFF_FFFF, mk(0, 31, 32'd0, 0, 0, 0, 0, 32'd0, 0, 1));
        issue(32'h0000_0073, mk(39, 31, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0));
        issue(32'h0200_1093, mk(0, 31, 32'd0, 0, 0, 0, 0, 32'd0, 0, 1));
        issue(32'h1234_52B7, mk(1, 16, 32'h1234_5000, 5, 0, 0, 0, 32'd4, 0, 0));
        issue(32'h0050_2423, mk(18, 0, 32'd8, 0, 0, 5, 0, 32'd4, 2, 0));
        issue(32'hFF9F_F0EF, mk(3, 0, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'hFFFF_FFF8, 0, 0));
        issue(32'h0000_8067, mk(4, 0, 32'd0, 0, 1, 0, 0, 32'd0, 1, 0));
        issue(32'h0010_0073, mk(40, 31, 32'd0, 0, 0, 0, 0, 32'd4, 0, 0));
        issue(32'h0050_0093, mk(19, 0, 32'd5, 1, 0, 0, 0, 32'd4, 0, 0));

        // Reset in the middle of a stall drops the pending request and the recorded rd.
        @(negedge soc_clk);
        Cu_IR = 32'h0020_8133;
        decode_start = 1'b1;
        IDU_stall = 1'b1;
        @(negedge soc_clk);
        decode_start = 1'b0;
        reset = 1'b0;
        #1;
        chk("midstall_reset_ready",   98'(IDU_ready), 98'(0));
        chk("midstall_reset_outputs", 98'(act_now),   98'(0));
        @(negedge soc_clk);
        reset = 1'b1;
        @(negedge soc_clk);
        IDU_stall = 1'b0;
        repeat (3) @(negedge soc_clk);
        issue(32'h0020_8133, mk(28, 0, 32'd0, 2, 1, 2, 0, 32'd4, 0, 0));

        repeat (4) @(negedge soc_clk);
        chk("missing_ready", 98'(exp_q.size()), 98'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cu_id.md
CU_ID -- requirements
Module: CU_ID

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; ports are named as the codebase names them (soc_clk, reset).
REQ-002 soc_clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 decode_start  in  1  request to decode Cu_IR.
REQ-005 IDU_stall  in  1  hazard stall; blocks decode while high.
REQ-006 Cu_IR  in  32  RV32I instruction word.
REQ-007 IDU_ready  out  1  one-cycle pulse; decoded outputs are valid.
REQ-008 Instruction_to_CU  out  6  instruction code: 0 invalid, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5-10 BEQ/BNE/BLT/BGE/BLTU/BGEU, 11-15 LB/LH/LW/LBU/LHU, 16-18 SB/SH/SW, 19-27 ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, 28-37 ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, 38 FENCE, 39 ECALL, 40 EBREAK.
REQ-009 Instruction_to_ALU  out  5  ALU op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10-15 EQ/NE/LT/GE/LTU/GEU, 16 PASS-imm, 31 none.
REQ-010 imm  out  32  sign-extended immediate.
REQ-011 rd, rs1, rs2  out  5 each  register indices.
REQ-012 shamt  out  5  shift amount.
REQ-013 pc_increment  out  32  PC offset for this instruction.
REQ-014 pipeline_override  out  2  forwarding flag: 00 none, 01 rs1, 10 rs2, 11 both.
REQ-015 invalid_instruction  out  1  current word is not a legal RV32I instruction.

Function
REQ-016 A decode fires on a rising edge where decode_start=1 and IDU_stall=0; all outputs are registered at that edge and IDU_ready=1 for exactly that cycle.
REQ-017 decode_start sampled while IDU_stall=1 is latched as pending; the decode fires on the first edge with IDU_stall=0, using Cu_IR present at that edge.
REQ-018 Outputs other than IDU_ready hold their values between decodes.
REQ-019 Opcode mapping: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR (funct3=000), 1100011 branch, 0000011 load, 0100011 store, 0010011 OP-IMM, 0110011 OP, 0001111 FENCE, 1110011 ECALL (IR=0x00000073) / EBREAK (IR=0x00100073).
REQ-020 ALU op: R/I arithmetic map to the matching op (SUB/SRA/SRAI use funct7=0100000, all others funct7=0000000); branches map to 10-15; loads, stores, AUIPC, JAL, JALR map to ADD; LUI maps to PASS-imm; FENCE/ECALL/EBREAK/invalid map to none (31).
REQ-021 imm: I {20{IR[31]},IR[31:20]}; S {IR[31:25],IR[11:7]} sign-extended; B {IR[31],IR[7],IR[30:25],IR[11:8],0} sign-extended; U {IR[31:12],12'b0}; J {IR[31],IR[19:12],IR[20],IR[30:21],0} sign-extended; R-type/system 0.
REQ-022 Fields not used by a format SHALL be 0: rd for S/B; rs2 for I/U/J; rs1 for U/J.
REQ-023 shamt = IR[24:20] for SLLI/SRLI/SRAI, else 0; a shift-immediate with IR[25]=1 is invalid.
REQ-024 pc_increment: JAL = J-imm; branches = B-imm; JALR = 0 (target computed by the CU); all others = 4.
REQ-025 Any unlisted opcode/funct3/funct7 combination SHALL set invalid_instruction=1, Instruction_to_CU=0 and ALU op=31, and zero all other data outputs; invalid_instruction is updated on every decode.
REQ-026 The block records the rd of the last valid decode when that instruction writes a register (R, I, U, J, load).
REQ-027 pipeline_override[0]=1 when the new rs1 is used, nonzero, and equal to the recorded rd; bit[1] is set likewise for rs2.
REQ-028 After an invalid, store, branch, FENCE or system decode, the recorded rd is cleared to 0, so no override is produced.

Reset
REQ-029 While reset=0, all outputs are 0, the pending request is cleared, and the recorded rd is 0; this applies immediately, including mid-stall.
REQ-030 The first decode after reset SHALL never assert pipeline_override.

Verification
REQ-031 Assert reset -> all outputs 0; release reset, hold decode_start=0 -> IDU_ready stays 0.
REQ-032 IR=0x00500093, decode_start=1 -> one-cycle IDU_ready; CU=19, ALU=0, rd=1, rs1=0, rs2=0, imm=5, pc_increment=4, override=00.
REQ-033 Then IR=0x00208133 -> CU=28, rd=2, rs1=1, rs2=2, override=01.
REQ-034 IR=0xFE000EE3 -> CU=5, ALU=10, rd=0, imm=0xFFFFFFFC, pc_increment=0xFFFFFFFC.
REQ-035 IR=0x4040D193 with IDU_stall=1 for 3 cycles -> no IDU_ready while stalled; after stall drops, one pulse with CU=27, ALU=7, shamt=4, rd=3.
REQ-036 IR=0xFFFFFFFF -> invalid_instruction=1, CU=0, ALU=31; next IR=0x00000073 -> invalid_instruction=0, CU=39.
